// File: rtl/rr_burst_arbiter_if.sv
// Shared arbiter package (state enum, default burst cap) and the
// requester/resource bundle used as the arbiter's port.
package rr_arb_pkg;
    localparam int unsigned MAX_BURST = 4;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;
endpackage

interface rr_burst_arbiter_if #(
    parameter int unsigned N = 4
);
    localparam int unsigned IW = $clog2(N);

    logic [N-1:0]           i_req;
    logic [N-1:0]           i_last;
    logic                   i_ready;
    logic                   o_valid;
    logic [N-1:0]           o_gnt;
    logic [IW-1:0]          o_gnt_id;
    rr_arb_pkg::arb_state_e o_state;
    logic                   o_abort;

    modport master (
        output i_req, i_last, i_ready,
        input  o_valid, o_gnt, o_gnt_id, o_state, o_abort
    );

    modport slave (
        input  i_req, i_last, i_ready,
        output o_valid, o_gnt, o_gnt_id, o_state, o_abort
    );
endinterface

// File: rtl/rr_burst_arbiter.sv
// Round-robin burst arbiter: grants one requester at a time and holds the
// grant until its last beat, the burst cap, or withdrawal of its request.
module rr_burst_arbiter #(
    parameter int unsigned N         = 4,
    parameter int unsigned MAX_BURST = rr_arb_pkg::MAX_BURST
) (
    input logic               i_clk,
    input logic               i_rst,
    rr_burst_arbiter_if.slave bus
);
    import rr_arb_pkg::*;

    localparam int unsigned IW = $clog2(N);
    localparam int unsigned CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BURST - 1);

    arb_state_e    state_q, state_d;
    logic [N-1:0]  gnt_q, gnt_d;
    logic [IW-1:0] id_q, id_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          abort_q, abort_d;

    logic [IW-1:0] sel, idx, id_next;
    logic          found, valid, accept, end_burst, withdraw;

    // Rotating-priority search: first requester at or after ptr, modulo N.
    always_comb begin
        sel   = ptr_q;
        idx   = ptr_q;
        found = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = IW'((32'(ptr_q) + i) % N);
            if (!found && bus.i_req[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
    end

    assign id_next   = (id_q == IW'(N - 1)) ? '0 : id_q + 1'b1;
    assign valid     = (state_q == BUSY) && bus.i_req[id_q];
    assign accept    = valid && bus.i_ready;
    assign end_burst = accept && (bus.i_last[id_q] || (cnt_q == CNT_LAST));
    assign withdraw  = (state_q == BUSY) && !bus.i_req[id_q];

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        id_d    = id_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        abort_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = BUSY;
                    id_d    = sel;
                    gnt_d   = N'(1) << sel;
                    cnt_d   = '0;
                end
            end
            BUSY: begin
                if (withdraw) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    ptr_d   = id_next;
                    abort_d = 1'b1;
                end else if (end_burst) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    ptr_d   = id_next;
                end else if (accept) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            id_q    <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            id_q    <= id_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            abort_q <= abort_d;
        end
    end

    assign bus.o_valid  = valid;
    assign bus.o_gnt    = gnt_q;
    assign bus.o_gnt_id = id_q;
    assign bus.o_state  = state_q;
    assign bus.o_abort  = abort_q;
endmodule

// File: tb/tb_rr_burst_arbiter.sv
// Bench for rr_burst_arbiter: directed scenarios with literal expectations
// followed by random traffic, all compared against a behavioural model.
module tb_rr_burst_arbiter;
    import rr_arb_pkg::*;

    localparam int N  = 4;
    localparam int MB = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    rr_burst_arbiter_if #(.N(N)) bus ();

    rr_burst_arbiter #(.N(N), .MAX_BURST(MB)) dut (
        .i_clk (clk),
        .i_rst (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [N-1:0] req_v  = '0;
    logic [N-1:0] last_v = '0;
    logic         rdy_v  = 1'b0;
    logic         rst_v  = 1'b0;

    // Model: who owns the resource, how many beats it has moved, where
    // priority starts next, and whether the last release was an abort.
    bit m_on    = 1'b0;
    bit m_busy  = 1'b0;
    bit m_abort = 1'b0;
    int m_owner = 0;
    int m_ptr   = 0;
    int m_beats = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        logic [N-1:0] eg;
        logic         ev;
        eg = m_busy ? (N'(1) << m_owner) : '0;
        ev = m_busy && req_v[m_owner];
        chk("model_gnt",   32'(bus.o_gnt),    32'(eg));
        chk("model_id",    32'(bus.o_gnt_id), 32'(m_owner));
        chk("model_state", 32'(bus.o_state),  32'(m_busy));
        chk("model_valid", 32'(bus.o_valid),  32'(ev));
        chk("model_abort", 32'(bus.o_abort),  32'(m_abort));
    endtask

    task automatic model_edge();
        bit found;
        if (!rst_v) begin
            m_on = 1'b1; m_busy = 1'b0; m_abort = 1'b0;
            m_owner = 0; m_ptr = 0; m_beats = 0;
        end else if (m_on) begin
            m_abort = 1'b0;
            if (!m_busy) begin
                found = 1'b0;
                for (int k = 0; k < N; k++) begin
                    if (!found && req_v[(m_ptr + k) % N]) begin
                        found   = 1'b1;
                        m_busy  = 1'b1;
                        m_owner = (m_ptr + k) % N;
                        m_beats = 0;
                    end
                end
            end else if (!req_v[m_owner]) begin
                m_busy  = 1'b0;
                m_abort = 1'b1;
                m_ptr   = (m_owner + 1) % N;
            end else if (rdy_v) begin
                m_beats++;
                if (last_v[m_owner] || m_beats == MB) begin
                    m_busy = 1'b0;
                    m_ptr  = (m_owner + 1) % N;
                end
            end
        end
    endtask

    // One clock cycle: drive inputs, check against the model, take the edge.
    task automatic step(input logic [N-1:0] r, input logic [N-1:0] l,
                        input logic rdy, input logic rn);
        @(negedge clk);
        req_v = r; last_v = l; rdy_v = rdy; rst_v = rn;
        bus.i_req = r; bus.i_last = l; bus.i_ready = rdy; rst_n = rn;
        #1;
        if (m_on) compare_model();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        step('0, '0, 1'b0, 1'b0);
        step('0, '0, 1'b0, 1'b0);
    endtask

    logic [N-1:0] rq, ls, msk;

    initial begin
        bus.i_req = '0; bus.i_last = '0; bus.i_ready = 1'b0;

        // Reset values, then 1010 grants requester 1, then requester 3.
        do_reset();
        chk("rst_gnt",   32'(bus.o_gnt),    32'h0);
        chk("rst_id",    32'(bus.o_gnt_id), 32'h0);
        chk("rst_state", 32'(bus.o_state),  32'h0);
        chk("rst_abort", 32'(bus.o_abort),  32'h0);
        step(4'b1010, 4'b0000, 1'b0, 1'b1);
        chk("t1_gnt", 32'(bus.o_gnt),    32'b0010);
        chk("t1_id",  32'(bus.o_gnt_id), 32'd1);
        step(4'b1010, 4'b0010, 1'b1, 1'b1);
        chk("t1_rel_state", 32'(bus.o_state), 32'h0);
        step(4'b1010, 4'b0000, 1'b0, 1'b1);
        chk("t1_next_gnt", 32'(bus.o_gnt), 32'b1000);

        // Burst cap: four beats, then regrant after one bubble.
        do_reset();
        step(4'b0001, 4'b0000, 1'b1, 1'b1);
        for (int b = 0; b < 3; b++) step(4'b0001, 4'b0000, 1'b1, 1'b1);
        chk("t2_held_after3", 32'(bus.o_gnt), 32'b0001);
        step(4'b0001, 4'b0000, 1'b1, 1'b1);
        chk("t2_drop_after4", 32'(bus.o_gnt), 32'b0000);
        step(4'b0001, 4'b0000, 1'b1, 1'b1);
        chk("t2_regrant", 32'(bus.o_gnt), 32'b0001);

        // Last beat at requester 3 wraps the pointer to 0.
        do_reset();
        step(4'b1000, 4'b0000, 1'b0, 1'b1);
        chk("t3_gnt3", 32'(bus.o_gnt), 32'b1000);
        step(4'b1000, 4'b1000, 1'b1, 1'b1);
        step(4'b1001, 4'b0000, 1'b0, 1'b1);
        chk("t3_wrap_id", 32'(bus.o_gnt_id), 32'd0);

        // Stall with ready low keeps the grant and the beat count.
        do_reset();
        step(4'b0100, 4'b0000, 1'b0, 1'b1);
        for (int b = 0; b < 5; b++) step(4'b0100, 4'b0100, 1'b0, 1'b1);
        chk("t4_stall_gnt", 32'(bus.o_gnt), 32'b0100);
        for (int b = 0; b < 3; b++) step(4'b0100, 4'b0000, 1'b1, 1'b1);
        chk("t4_busy_after3", 32'(bus.o_state), 32'h1);
        step(4'b0100, 4'b0000, 1'b1, 1'b1);
        chk("t4_idle_after4", 32'(bus.o_state), 32'h0);

        // Withdrawal after two beats aborts; pointer moves to 2.
        do_reset();
        step(4'b0010, 4'b0000, 1'b0, 1'b1);
        step(4'b0010, 4'b0000, 1'b1, 1'b1);
        step(4'b0010, 4'b0000, 1'b1, 1'b1);
        step(4'b0000, 4'b0000, 1'b1, 1'b1);
        chk("t5_abort",       32'(bus.o_abort), 32'h1);
        chk("t5_abort_state", 32'(bus.o_state), 32'h0);
        chk("t5_abort_gnt",   32'(bus.o_gnt),   32'h0);
        step(4'b0110, 4'b0000, 1'b0, 1'b1);
        chk("t5_abort_clear", 32'(bus.o_abort),  32'h0);
        chk("t5_ptr2",        32'(bus.o_gnt_id), 32'd2);

        // Reset mid-burst, then all requesting grants requester 0.
        do_reset();
        step(4'b1111, 4'b0000, 1'b0, 1'b1);
        step(4'b1111, 4'b0000, 1'b1, 1'b1);
        step(4'b1111, 4'b0000, 1'b1, 1'b1);
        step(4'b1111, 4'b0000, 1'b1, 1'b0);
        chk("t6_rst_gnt",   32'(bus.o_gnt),   32'h0);
        chk("t6_rst_state", 32'(bus.o_state), 32'h0);
        chk("t6_rst_abort", 32'(bus.o_abort), 32'h0);
        step(4'b1111, 4'b0000, 1'b0, 1'b1);
        chk("t6_first_gnt", 32'(bus.o_gnt), 32'b0001);

        // Random traffic: sticky requests with sparse toggles.
        rq = 4'b0101;
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < N; b++) begin
                msk[b] = ($urandom_range(0, 7) == 0);
                ls[b]  = ($urandom_range(0, 5) == 0);
            end
            rq = rq ^ msk;
            step(rq, ls, ($urandom_range(0, 3) != 0), ($urandom_range(0, 299) != 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
